// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   state_t  : arbiter FSM encoding (IDLE=0, WAIT=1)
//   owner_t  : which port owns the in-flight access (OWN_IF=0, OWN_DM=1)
//   LAT_W    : width of the read-latency down-counter
//   STARVE_W : width of the instruction-starvation counter
package mem_arb_pkg;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;
    localparam int LAT_W    = 3;
    localparam int STARVE_W = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the SRAM.
//   slave  : arbiter view (requests and SRAM read data in; responses and SRAM drive out)
//   master : pipeline/SRAM view (the mirror image)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rvalid;
    logic              dm_req;
    logic [3:0]        dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_rvalid;
    logic [3:0]        mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_rvalid, dm_rdata, dm_rvalid,
               mem_w_en, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_rvalid, dm_rdata, dm_rvalid,
               mem_w_en, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb_prio.sv
// Grant logic: data port wins ties unless the instruction port has been
// passed over STARVE_MAX times in a row.
//   clk, rst  : clock, synchronous active-low reset
//   if_req    : instruction request
//   dm_req    : data request (already masked by the caller where needed)
//   grant_en  : arbitration allowed this cycle
//   grant_if  : instruction port wins
//   grant_dm  : data port wins
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant_en,
    output logic grant_if,
    output logic grant_dm
);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;
    logic                if_starved;

    assign if_starved = if_req && (starve_cnt == STARVE_LIM);

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (grant_en) begin
            if (dm_req && !if_starved)
                grant_dm = 1'b1;
            else if (if_req)
                grant_if = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            starve_cnt <= '0;
        else if (grant_if)
            starve_cnt <= '0;
        else if (grant_dm) begin
            if (!if_req)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the fetch port (read-only) and the
// MEM-stage data port. Writes complete in the issue cycle and ack one cycle
// later; reads hold the address through MEM_LAT wait cycles and pulse the
// owner's rvalid in the last one.
//   clk, rst : clock, synchronous active-low reset
//   bus      : request/response/SRAM signals (slave view)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    state_t              state, state_nxt;
    logic [LAT_W-1:0]    lat_cnt, lat_nxt;
    owner_t              owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_mux;
    logic [3:0]          w_en;
    logic [DATA_W-1:0]   rdata;
    logic                wr_ack_q;
    logic                rd_done;
    logic                grant_en, grant_if, grant_dm, dm_is_wr;

    // No grant during reset so mem_w_en stays quiet; no DM re-grant in its
    // write-ack cycle because the requester is still dropping dm_req.
    assign grant_en = rst && (state == IDLE);
    assign dm_is_wr = (bus.dm_we != 4'b0000);

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk      (clk),
        .rst      (rst),
        .if_req   (bus.if_req),
        .dm_req   (bus.dm_req && !wr_ack_q),
        .grant_en (grant_en),
        .grant_if (grant_if),
        .grant_dm (grant_dm)
    );

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        addr_mux  = addr_q;
        w_en      = 4'b0000;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_dm) begin
                    addr_mux = bus.dm_addr;
                    w_en     = bus.dm_we;
                    if (!dm_is_wr) begin
                        state_nxt = WAIT;
                        lat_nxt   = LAT_W'(MEM_LAT - 1);
                    end
                end else if (grant_if) begin
                    addr_mux  = bus.if_addr;
                    state_nxt = WAIT;
                    lat_nxt   = LAT_W'(MEM_LAT - 1);
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    lat_nxt = lat_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_nxt;
            wr_ack_q <= grant_dm && dm_is_wr;
            if (grant_if || grant_dm) begin
                addr_q  <= addr_mux;
                owner_q <= grant_dm ? OWN_DM : OWN_IF;
            end
        end
    end

    assign rdata         = bus.mem_rdata;
    assign bus.if_rdata  = rdata;
    assign bus.dm_rdata  = rdata;
    assign bus.if_rvalid = rd_done && (owner_q == OWN_IF);
    assign bus.dm_rvalid = (rd_done && (owner_q == OWN_DM)) || wr_ack_q;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_w_en  = w_en;
    assign bus.mem_wdata = bus.dm_wdata;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 1, 2, 3) share a clock/reset and a
// word-wide SRAM model with a one-cycle registered read port per instance.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b2 ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b3 ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4))
        u1 (.clk(clk), .rst(rst), .bus(b1));
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4))
        u2 (.clk(clk), .rst(rst), .bus(b2));
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4))
        u3 (.clk(clk), .rst(rst), .bus(b3));

    logic [31:0] sram [0:16383];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (b1.mem_w_en[b]) sram[b1.mem_addr[15:2]][b*8 +: 8] <= b1.mem_wdata[b*8 +: 8];
        b1.mem_rdata <= sram[b1.mem_addr[15:2]];
        b2.mem_rdata <= sram[b2.mem_addr[15:2]];
        b3.mem_rdata <= sram[b3.mem_addr[15:2]];
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        b1.dm_req = 1'b1;
        b1.dm_we  = 4'hF;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (b1.mem_w_en !== 4'h0) begin
            errors++; $display("FAIL reset_wen got=%h exp=0", b1.mem_w_en);
        end
        checks++;
        if ({b1.busy, b1.if_rvalid, b1.dm_rvalid} !== 3'b000) begin
            errors++; $display("FAIL reset_outs got=%b exp=000", {b1.busy, b1.if_rvalid, b1.dm_rvalid});
        end
        checks++;
        if (u1.u_prio.starve_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_starve got=%0d exp=0", u1.u_prio.starve_cnt);
        end
        next_cycle();
        b1.dm_req = 1'b0;
        b1.dm_we  = 4'h0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_if_read;
        b1.if_req  = 1'b1;
        b1.if_addr = 16'h0040;
        @(negedge clk);
        checks++;
        if (b1.mem_addr !== 16'h0040 || b1.busy !== 1'b0 || b1.if_rvalid !== 1'b0) begin
            errors++; $display("FAIL ifrd_T addr=%h busy=%b rv=%b exp 0040/0/0", b1.mem_addr, b1.busy, b1.if_rvalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (b1.if_rvalid !== 1'b1 || b1.if_rdata !== 32'h00A00093 || b1.busy !== 1'b1) begin
            errors++; $display("FAIL ifrd_T1 rv=%b data=%h busy=%b exp 1/00a00093/1", b1.if_rvalid, b1.if_rdata, b1.busy);
        end
        next_cycle();
        b1.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b1.if_rvalid !== 1'b0 || b1.busy !== 1'b0) begin
            errors++; $display("FAIL ifrd_T2 rv=%b busy=%b exp 0/0", b1.if_rvalid, b1.busy);
        end
        next_cycle();
    endtask

    task automatic test_simultaneous;
        b1.if_req  = 1'b1;
        b1.if_addr = 16'h0040;
        b1.dm_req  = 1'b1;
        b1.dm_we   = 4'h0;
        b1.dm_addr = 16'h1000;
        @(negedge clk);
        checks++;
        if (b1.mem_addr !== 16'h1000 || b1.mem_w_en !== 4'h0) begin
            errors++; $display("FAIL sim_T addr=%h wen=%h exp 1000/0", b1.mem_addr, b1.mem_w_en);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (b1.dm_rvalid !== 1'b1 || b1.dm_rdata !== 32'h11223344 || b1.if_rvalid !== 1'b0) begin
            errors++; $display("FAIL sim_T1 dmrv=%b data=%h ifrv=%b exp 1/11223344/0", b1.dm_rvalid, b1.dm_rdata, b1.if_rvalid);
        end
        next_cycle();
        b1.dm_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b1.mem_addr !== 16'h0040 || b1.dm_rvalid !== 1'b0) begin
            errors++; $display("FAIL sim_T2 addr=%h dmrv=%b exp 0040/0", b1.mem_addr, b1.dm_rvalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (b1.if_rvalid !== 1'b1 || b1.if_rdata !== 32'h00A00093) begin
            errors++; $display("FAIL sim_T3 ifrv=%b data=%h exp 1/00a00093", b1.if_rvalid, b1.if_rdata);
        end
        next_cycle();
        b1.if_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_store;
        b1.dm_req   = 1'b1;
        b1.dm_we    = 4'b0011;
        b1.dm_addr  = 16'h2004;
        b1.dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (b1.mem_w_en !== 4'b0011 || b1.mem_addr !== 16'h2004 || b1.mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL st_T wen=%b addr=%h wd=%h exp 0011/2004/deadbeef", b1.mem_w_en, b1.mem_addr, b1.mem_wdata);
        end
        checks++;
        if (b1.dm_rvalid !== 1'b0 || b1.busy !== 1'b0) begin
            errors++; $display("FAIL st_T_rv rv=%b busy=%b exp 0/0", b1.dm_rvalid, b1.busy);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (b1.dm_rvalid !== 1'b1 || b1.mem_w_en !== 4'h0) begin
            errors++; $display("FAIL st_T1 rv=%b wen=%b exp 1/0000", b1.dm_rvalid, b1.mem_w_en);
        end
        next_cycle();
        b1.dm_req = 1'b0;
        b1.dm_we  = 4'h0;
        @(negedge clk);
        checks++;
        if (sram[16'h2004 >> 2] !== 32'h5566BEEF || b1.dm_rvalid !== 1'b0) begin
            errors++; $display("FAIL st_mem word=%h rv=%b exp 5566beef/0", sram[16'h2004 >> 2], b1.dm_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_starvation;
        int ndm = 0;
        bit got = 1'b0;
        b1.if_req  = 1'b1;
        b1.if_addr = 16'h0040;
        b1.dm_req  = 1'b1;
        b1.dm_we   = 4'h0;
        b1.dm_addr = 16'h1000;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (b1.dm_rvalid) ndm++;
            if (b1.if_rvalid) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        checks++;
        if (!got || ndm != 4) begin
            errors++; $display("FAIL starve_grants if_done=%b dm_grants=%0d exp 1/4", got, ndm);
        end
        next_cycle();
        b1.if_req = 1'b0;
        b1.dm_req = 1'b0;
        @(negedge clk);
        checks++;
        if (u1.u_prio.starve_cnt !== 4'd0) begin
            errors++; $display("FAIL starve_cnt got=%0d exp=0", u1.u_prio.starve_cnt);
        end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_latency;
        logic [6:0] exp_if;
        b3.dm_req  = 1'b1;
        b3.dm_we   = 4'h0;
        b3.dm_addr = 16'h1000;
        exp_if = 7'b0000000;
        exp_if[6] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (t == 1) begin
                b3.if_req  = 1'b1;
                b3.if_addr = 16'h0040;
            end
            @(negedge clk);
            checks++;
            if (b3.mem_addr !== 16'h1000 || b3.dm_rvalid !== (t == 3) || b3.if_rvalid !== 1'b0) begin
                errors++; $display("FAIL lat_T%0d addr=%h dmrv=%b ifrv=%b exp 1000/%0d/0", t, b3.mem_addr, b3.dm_rvalid, b3.if_rvalid, t == 3);
            end
            if (t == 3) begin
                checks++;
                if (b3.dm_rdata !== 32'h11223344) begin
                    errors++; $display("FAIL lat_data got=%h exp=11223344", b3.dm_rdata);
                end
            end
            next_cycle();
        end
        b3.dm_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b3.mem_addr !== 16'h0040 || b3.busy !== 1'b0) begin
            errors++; $display("FAIL lat_T4 addr=%h busy=%b exp 0040/0", b3.mem_addr, b3.busy);
        end
        for (int t = 5; t < 8; t++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (b3.if_rvalid !== exp_if[t-1]) begin
                errors++; $display("FAIL lat_if_T%0d got=%b exp=%b", t, b3.if_rvalid, exp_if[t-1]);
            end
        end
        next_cycle();
        b3.if_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_read;
        b2.if_req  = 1'b1;
        b2.if_addr = 16'h0040;
        @(negedge clk);
        checks++;
        if (b2.mem_addr !== 16'h0040) begin
            errors++; $display("FAIL rmid_T addr=%h exp=0040", b2.mem_addr);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (b2.busy !== 1'b1) begin
            errors++; $display("FAIL rmid_T1 busy=%b exp=1", b2.busy);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (b2.if_rvalid !== 1'b0 || b2.busy !== 1'b0 || b2.mem_w_en !== 4'h0) begin
            errors++; $display("FAIL rmid_T2 rv=%b busy=%b wen=%h exp 0/0/0", b2.if_rvalid, b2.busy, b2.mem_w_en);
        end
        next_cycle();
        b2.if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b2.if_rvalid !== 1'b0 || b2.busy !== 1'b0) begin
            errors++; $display("FAIL rmid_T3 rv=%b busy=%b exp 0/0", b2.if_rvalid, b2.busy);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic init_bus;
        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
        b2.if_req = 0; b2.if_addr = 0; b2.dm_req = 0; b2.dm_we = 0; b2.dm_addr = 0; b2.dm_wdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = 0; b3.dm_wdata = 0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
        sram[16'h0040 >> 2] = 32'h00A00093;
        sram[16'h1000 >> 2] = 32'h11223344;
        sram[16'h2004 >> 2] = 32'h55667788;
        init_bus();
        rst = 1'b0;
        next_cycle();
        test_reset();
        test_if_read();
        test_simultaneous();
        test_store();
        test_starvation();
        test_latency();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
